// File: rtl/sq_pkg.sv
// Shared store-queue types: access sizes and the byte-lane placement helpers used at
// enqueue and on the load-forwarding path.
package sq_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // Helpers work on the widest supported word; callers truncate to their own width.
    localparam int MAX_WORD_BYTES = 8;
    localparam int MAX_WORD_BITS  = 8 * MAX_WORD_BYTES;

    typedef logic [MAX_WORD_BYTES-1:0] mask_t;
    typedef logic [MAX_WORD_BITS-1:0]  wide_t;
    typedef logic [2:0]                lo_t;

    function automatic mask_t byte_mask(input lo_t addr_lo, input size_t size);
        mask_t m;
        case (size)
            SZ_BYTE: m = mask_t'(1);
            SZ_HALF: m = mask_t'(3);
            default: m = '1;
        endcase
        return m << addr_lo;
    endfunction

    function automatic wide_t lane_shift(input wide_t data, input lo_t addr_lo);
        return data << {addr_lo, 3'b000};
    endfunction

endpackage

// File: rtl/sq_fwd_lane.sv
// One byte lane of the forwarding network: picks the youngest matching entry, scanning
// from tail-1 back towards head in circular order.
module sq_fwd_lane #(
    parameter int N = 8
) (
    input  logic [N-1:0]         match,
    input  logic [N-1:0][7:0]    entry_byte,
    input  logic [$clog2(N)-1:0] head,
    input  logic [$clog2(N)-1:0] tail,
    output logic                 covered,
    output logic [7:0]           lane_byte
);

    localparam int PW = $clog2(N);
    typedef logic [PW-1:0] ptr_t;

    logic done;
    ptr_t idx;

    // NOTE: every variable written here gets a default first, so no latch is inferred
    // and blocking assignments give the intended sequential scan semantics.
    always_comb begin
        covered   = 1'b0;
        lane_byte = '0;
        done      = 1'b0;
        idx       = tail - ptr_t'(1);
        for (int i = 0; i < N; i++) begin
            if (!done && match[idx]) begin
                covered   = 1'b1;
                lane_byte = entry_byte[idx];
                done      = 1'b1;
            end
            // head is the oldest entry; when full the walk reaches it only on the last step
            if (idx == head) begin
                done = 1'b1;
            end
            idx = idx - ptr_t'(1);
        end
    end

endmodule

// File: rtl/store_queue.sv
// Store queue: holds in-flight stores in program order, drains committed stores to the
// D-cache write port and forwards store bytes to loads.
module store_queue
    import sq_pkg::*;
#(
    parameter int N               = 8,
    parameter int WORD_SIZE       = 32,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int ROB_ENTRY_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [ADDRESS_WIDTH-1:0]   alloc_addr,
    input  logic [WORD_SIZE-1:0]       alloc_data,
    input  size_t                      alloc_size,
    input  logic [ROB_ENTRY_WIDTH-1:0] alloc_rob_id,
    input  logic                       commit_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id,
    input  logic                       flush,
    input  logic [ADDRESS_WIDTH-1:0]   ld_addr,
    input  size_t                      ld_size,
    output logic                       fwd_hit,
    output logic                       fwd_conflict,
    output logic [WORD_SIZE-1:0]       fwd_data,
    output logic                       cache_req_valid,
    input  logic                       cache_req_ready,
    output logic [ADDRESS_WIDTH-1:0]   cache_req_addr,
    output logic [WORD_SIZE-1:0]       cache_req_data,
    output logic [WORD_SIZE/8-1:0]     cache_req_be,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(N):0]         count
);

    localparam int BPW = WORD_SIZE / 8;
    localparam int OFF = $clog2(BPW);
    localparam int PW  = $clog2(N);
    localparam int CW  = PW + 1;
    localparam int WAW = ADDRESS_WIDTH - OFF;

    typedef logic [PW-1:0] ptr_t;

    logic [N-1:0]               valid, committed;
    logic [WAW-1:0]             ent_waddr [N];
    logic [BPW-1:0]             ent_be    [N];
    logic [WORD_SIZE-1:0]       ent_data  [N];
    logic [ROB_ENTRY_WIDTH-1:0] ent_rob   [N];

    ptr_t           head, tail;
    logic [CW-1:0]  ncommit;

    logic           push, pop;
    logic           commit_hit;
    ptr_t           commit_idx, scan_idx;
    logic [N-1:0]   valid_n, committed_n;
    ptr_t           head_n, tail_n;
    logic [CW-1:0]  count_n, ncommit_n;

    logic [BPW-1:0]       alloc_be;
    logic [WORD_SIZE-1:0] alloc_lane_data;

    assign full            = (count == CW'(N));
    assign empty           = (count == '0);
    assign alloc_ready     = !full && !flush;
    assign push            = alloc_valid && alloc_ready;
    assign cache_req_valid = valid[head] && committed[head];
    assign pop             = cache_req_valid && cache_req_ready;

    assign alloc_be        = BPW'(byte_mask(lo_t'(alloc_addr[OFF-1:0]), alloc_size));
    assign alloc_lane_data = WORD_SIZE'(lane_shift(wide_t'(alloc_data), lo_t'(alloc_addr[OFF-1:0])));

    // Oldest valid, uncommitted entry carrying the retiring ROB id.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        scan_idx   = head;
        for (int i = 0; i < N; i++) begin
            if (commit_valid && !commit_hit && valid[scan_idx] && !committed[scan_idx] &&
                ent_rob[scan_idx] == commit_rob_id) begin
                commit_hit = 1'b1;
                commit_idx = scan_idx;
            end
            scan_idx = scan_idx + ptr_t'(1);
        end
    end

    // Same-edge events apply in order: commit, pop, flush, enqueue.
    always_comb begin
        valid_n     = valid;
        committed_n = committed;
        if (commit_hit) begin
            committed_n[commit_idx] = 1'b1;
        end
        if (pop) begin
            valid_n[head]     = 1'b0;
            committed_n[head] = 1'b0;
        end
        ncommit_n = ncommit + CW'(commit_hit) - CW'(pop);
        head_n    = pop ? head + ptr_t'(1) : head;
        if (flush) begin
            // Committed entries form a run from head, so the survivors end at head+ncommit.
            valid_n = valid_n & committed_n;
            tail_n  = head_n + ncommit_n[PW-1:0];
            count_n = ncommit_n;
        end else begin
            tail_n  = push ? tail + ptr_t'(1) : tail;
            count_n = count + CW'(push) - CW'(pop);
            if (push) begin
                valid_n[tail]     = 1'b1;
                committed_n[tail] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ncommit   <= '0;
            valid     <= '0;
            committed <= '0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            count     <= count_n;
            ncommit   <= ncommit_n;
            valid     <= valid_n;
            committed <= committed_n;
        end
    end

    // NOTE: the payload arrays are not reset; every read is qualified by a valid bit.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_waddr[tail] <= alloc_addr[ADDRESS_WIDTH-1:OFF];
            ent_be[tail]    <= alloc_be;
            ent_data[tail]  <= alloc_lane_data;
            ent_rob[tail]   <= alloc_rob_id;
        end
    end

    assign cache_req_addr = cache_req_valid ? {ent_waddr[head], {OFF{1'b0}}} : '0;
    assign cache_req_data = cache_req_valid ? ent_data[head] : '0;
    assign cache_req_be   = cache_req_valid ? ent_be[head]   : '0;

    // Store-to-load forwarding over entries valid at the start of the cycle.
    logic [WAW-1:0]       ld_waddr;
    logic [BPW-1:0]       ld_need, lane_covered;
    logic [N-1:0]         addr_match;
    logic [WORD_SIZE-1:0] gathered;
    logic                 all_covered;

    assign ld_waddr = ld_addr[ADDRESS_WIDTH-1:OFF];
    assign ld_need  = BPW'(byte_mask(lo_t'(ld_addr[OFF-1:0]), ld_size));

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_match[i] = valid[i] && (ent_waddr[i] == ld_waddr);
        end
    end

    for (genvar l = 0; l < BPW; l++) begin : g_lane
        logic [N-1:0]      lane_match;
        logic [N-1:0][7:0] lane_bytes;
        logic              lane_cov;
        logic [7:0]        lane_val;

        always_comb begin
            for (int i = 0; i < N; i++) begin
                lane_match[i] = addr_match[i] && ent_be[i][l];
                lane_bytes[i] = ent_data[i][8*l +: 8];
            end
        end

        sq_fwd_lane #(.N(N)) u_fwd_lane (
            .match      (lane_match),
            .entry_byte (lane_bytes),
            .head       (head),
            .tail       (tail),
            .covered    (lane_cov),
            .lane_byte  (lane_val)
        );

        assign lane_covered[l]    = lane_cov;
        assign gathered[8*l +: 8] = ld_need[l] ? lane_val : 8'h00;
    end

    assign all_covered  = ((ld_need & ~lane_covered) == '0);
    assign fwd_hit      = all_covered;
    assign fwd_conflict = !all_covered && |(ld_need & lane_covered);
    assign fwd_data     = all_covered ? (gathered >> {ld_addr[OFF-1:0], 3'b000}) : '0;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: forwarding checks inline, drained stores checked by a
// scoreboard monitor against the stores the bench has committed.
module tb_store_queue;
    import sq_pkg::*;

    localparam int N  = 8;
    localparam int WS = 32;
    localparam int AW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic [AW-1:0] alloc_addr = '0;
    logic [WS-1:0] alloc_data = '0;
    size_t         alloc_size = SZ_BYTE;
    logic [RW-1:0] alloc_rob_id = '0;
    logic          commit_valid = 1'b0;
    logic [RW-1:0] commit_rob_id = '0;
    logic          flush = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    size_t         ld_size = SZ_BYTE;
    logic          fwd_hit, fwd_conflict;
    logic [WS-1:0] fwd_data;
    logic          cache_req_valid;
    logic          cache_req_ready = 1'b0;
    logic [AW-1:0] cache_req_addr;
    logic [WS-1:0] cache_req_data;
    logic [3:0]    cache_req_be;
    logic          full, empty;
    logic [3:0]    count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t pend_q[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    store_queue #(.N(N), .WORD_SIZE(WS), .ADDRESS_WIDTH(AW), .ROB_ENTRY_WIDTH(RW)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_addr      (alloc_addr),
        .alloc_data      (alloc_data),
        .alloc_size      (alloc_size),
        .alloc_rob_id    (alloc_rob_id),
        .commit_valid    (commit_valid),
        .commit_rob_id   (commit_rob_id),
        .flush           (flush),
        .ld_addr         (ld_addr),
        .ld_size         (ld_size),
        .fwd_hit         (fwd_hit),
        .fwd_conflict    (fwd_conflict),
        .fwd_data        (fwd_data),
        .cache_req_valid (cache_req_valid),
        .cache_req_ready (cache_req_ready),
        .cache_req_addr  (cache_req_addr),
        .cache_req_data  (cache_req_data),
        .cache_req_be    (cache_req_be),
        .full            (full),
        .empty           (empty),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pend_q.delete();
        exp_q.delete();
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input size_t sz,
                         input logic [4:0] rob, input logic [3:0] exp_be, input logic [31:0] exp_data);
        exp_t e;
        alloc_valid  = 1'b1;
        alloc_addr   = addr;
        alloc_data   = data;
        alloc_size   = sz;
        alloc_rob_id = rob;
        #1 check("alloc_ready", alloc_ready, 1);
        tick();
        alloc_valid = 1'b0;
        e.addr = addr & ~32'h3;
        e.data = exp_data;
        e.be   = exp_be;
        pend_q.push_back(e);
    endtask

    task automatic commit(input logic [4:0] rob);
        commit_valid  = 1'b1;
        commit_rob_id = rob;
        tick();
        commit_valid = 1'b0;
        if (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    endtask

    task automatic load(input string name, input logic [31:0] addr, input size_t sz,
                        input logic exp_hit, input logic exp_conf, input logic [31:0] exp_data);
        ld_addr = addr;
        ld_size = sz;
        #1;
        check({name, "_hit"}, fwd_hit, exp_hit);
        check({name, "_conflict"}, fwd_conflict, exp_conf);
        check({name, "_data"}, fwd_data, exp_data);
    endtask

    // Scoreboard monitor: every accepted cache write must be the next committed store.
    always @(negedge clk) begin
        if (!rst && cache_req_valid && cache_req_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_extra: got write to 0x%0h, expected no write", cache_req_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("drain_addr", cache_req_addr, mon_e.addr);
                check("drain_data", cache_req_data, mon_e.data);
                check("drain_be", cache_req_be, mon_e.be);
            end
        end
    end

    initial begin
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_req_valid", cache_req_valid, 0);
        check("rst_req_addr", cache_req_addr, 0);
        check("rst_req_data", cache_req_data, 0);
        check("rst_req_be", cache_req_be, 0);
        load("rst_ld", 32'h1000, SZ_WORD, 0, 0, 0);

        // Basic forwarding from a single word store
        store(32'h1000, 32'hDEADBEEF, SZ_WORD, 5'd3, 4'hF, 32'hDEADBEEF);
        load("w_ld", 32'h1000, SZ_WORD, 1, 0, 32'hDEADBEEF);
        load("b_ld", 32'h1002, SZ_BYTE, 1, 0, 32'h000000AD);

        // Partial coverage, then younger overlapping stores
        store(32'h2001, 32'h00000055, SZ_BYTE, 5'd4, 4'b0010, 32'h00005500);
        load("part_ld", 32'h2000, SZ_WORD, 0, 1, 0);
        store(32'h2000, 32'h11223344, SZ_WORD, 5'd5, 4'hF, 32'h11223344);
        load("young_w", 32'h2000, SZ_WORD, 1, 0, 32'h11223344);
        store(32'h2001, 32'h00000055, SZ_BYTE, 5'd6, 4'b0010, 32'h00005500);
        load("young_h", 32'h2000, SZ_HALF, 1, 0, 32'h00005544);
        load("mix_w", 32'h2000, SZ_WORD, 1, 0, 32'h11225544);
        load("hi_h", 32'h2002, SZ_HALF, 1, 0, 32'h00001122);
        check("count4", count, 4);

        do_reset();
        check("rst2_empty", empty, 1);

        // Fill, reject when full, drain one per cycle
        cache_req_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            store(32'h3000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), SZ_WORD, 5'(i), 4'hF, 32'hC0DE0000 + 32'(i));
        end
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        alloc_valid = 1'b1;
        alloc_addr  = 32'h3100;
        alloc_size  = SZ_WORD;
        #1 check("fill_alloc_ready", alloc_ready, 0);
        tick();
        alloc_valid = 1'b0;
        check("fill_reject_count", count, 8);
        cache_req_ready = 1'b1;
        for (int j = 0; j < N; j++) begin
            commit(5'(j));
            check("drain_count", count, 64'(N - j));
        end
        tick();
        check("drain_empty", empty, 1);
        check("drain_count0", count, 0);

        // Move head off slot 0, then refill so the tail wraps
        for (int i = 0; i < 3; i++) begin
            store(32'h4000 + 32'(4 * i), 32'h40 + 32'(i), SZ_WORD, 5'(8 + i), 4'hF, 32'h40 + 32'(i));
        end
        for (int i = 0; i < 3; i++) commit(5'(8 + i));
        tick();
        check("pre_wrap_empty", empty, 1);
        store(32'h5010, 32'hA0000000, SZ_WORD, 5'd11, 4'hF, 32'hA0000000);
        store(32'h5014, 32'hA0000001, SZ_WORD, 5'd12, 4'hF, 32'hA0000001);
        store(32'h5018, 32'hA0000002, SZ_WORD, 5'd13, 4'hF, 32'hA0000002);
        store(32'h501C, 32'hA0000003, SZ_WORD, 5'd14, 4'hF, 32'hA0000003);
        store(32'h5000, 32'hAAAAAAAA, SZ_WORD, 5'd15, 4'hF, 32'hAAAAAAAA);
        store(32'h5000, 32'hBBBBBBBB, SZ_WORD, 5'd16, 4'hF, 32'hBBBBBBBB);
        store(32'h5020, 32'hA0000006, SZ_WORD, 5'd17, 4'hF, 32'hA0000006);
        store(32'h5024, 32'hA0000007, SZ_WORD, 5'd18, 4'hF, 32'hA0000007);
        check("wrap_full", full, 1);
        load("wrap_young", 32'h5000, SZ_WORD, 1, 0, 32'hBBBBBBBB);
        load("wrap_last", 32'h5024, SZ_BYTE, 1, 0, 32'h00000007);
        for (int j = 0; j < N; j++) commit(5'(11 + j));
        tick();
        check("wrap_drain_empty", empty, 1);

        // Flush keeps committed stores, squashes the rest, blocks enqueue
        cache_req_ready = 1'b0;
        store(32'h6003, 32'h0000007F, SZ_BYTE, 5'd20, 4'b1000, 32'h7F000000);
        store(32'h6006, 32'h0000BEEF, SZ_HALF, 5'd21, 4'b1100, 32'hBEEF0000);
        store(32'h6008, 32'h01020304, SZ_WORD, 5'd22, 4'hF, 32'h01020304);
        store(32'h600C, 32'h05060708, SZ_WORD, 5'd23, 4'hF, 32'h05060708);
        commit(5'd20);
        commit(5'd21);
        commit_valid  = 1'b1;
        commit_rob_id = 5'd31;
        tick();
        commit_valid = 1'b0;
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 32'h6100;
        alloc_data  = 32'h12345678;
        alloc_size  = SZ_WORD;
        #1 check("flush_alloc_ready", alloc_ready, 0);
        tick();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        pend_q.delete();
        check("flush_count", count, 2);
        load("flush_squashed", 32'h6008, SZ_WORD, 0, 0, 0);
        load("flush_blocked", 32'h6100, SZ_WORD, 0, 0, 0);
        load("flush_kept", 32'h6006, SZ_HALF, 1, 0, 32'h0000BEEF);
        cache_req_ready = 1'b1;
        tick();
        tick();
        tick();
        check("flush_drain_empty", empty, 1);
        check("sb_drained", exp_q.size(), 0);

        // Stalled request stays stable, then reset drops it
        cache_req_ready = 1'b0;
        store(32'h7000, 32'hCAFEF00D, SZ_WORD, 5'd1, 4'hF, 32'hCAFEF00D);
        commit(5'd1);
        check("stall_valid0", cache_req_valid, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", cache_req_valid, 1);
            check("stall_addr", cache_req_addr, 32'h7000);
            check("stall_data", cache_req_data, 32'hCAFEF00D);
            check("stall_be", cache_req_be, 4'hF);
        end
        do_reset();
        check("rst_stall_valid", cache_req_valid, 0);
        check("rst_stall_empty", empty, 1);
        check("rst_stall_addr", cache_req_addr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_queue.md
# store_queue

Parametrised store queue between the memory stage and the D-cache write port. It holds in-flight stores in program order and accepts commit notifications from the ROB by ROB id. Committed stores drain to the cache through a valid/ready handshake. Loads receive byte-granular store-to-load forwarding from the youngest overlapping stores, and a flush squashes all stores that have not yet committed.

## Interface
Parameters:
- N, 8, entry count; power of two, at least 2
- WORD_SIZE, 32, data width in bits; multiple of 8
- ADDRESS_WIDTH, 32, physical address width
- ROB_ENTRY_WIDTH, 5, ROB id width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset rst, synchronous, active-high
- alloc_valid  in  1  store presented for enqueue
- alloc_ready  out  1  `!full && !flush`
- alloc_addr  in  ADDRESS_WIDTH  byte address of the store
- alloc_data  in  WORD_SIZE  store data, LSB-aligned
- alloc_size  in  2  access size (sq_pkg size_t)
- alloc_rob_id  in  ROB_ENTRY_WIDTH  ROB id of the store
- commit_valid  in  1  ROB retires a store
- commit_rob_id  in  ROB_ENTRY_WIDTH  ROB id being retired
- flush  in  1  squash all uncommitted entries
- ld_addr  in  ADDRESS_WIDTH  load byte address
- ld_size  in  2  load size
- fwd_hit  out  1  every load byte is covered by queued stores
- fwd_conflict  out  1  some load bytes are covered, but not all; the load must stall
- fwd_data  out  WORD_SIZE  forwarded value, zero-extended
- cache_req_valid  out  1  head entry is committed
- cache_req_ready  in  1  cache accepts the write
- cache_req_addr  out  ADDRESS_WIDTH  word-aligned address
- cache_req_data  out  WORD_SIZE  lane-aligned data
- cache_req_be  out  WORD_SIZE/8  byte enables
- full, empty  out  1  occupancy flags
- count  out  $clog2(N)+1  number of valid entries

## Operation

**Entry contents**
- Each entry stores: word-aligned address, byte-enable mask, lane-shifted data, rob_id, committed bit.
- The mask and shift are derived from the address low bits and the access size at enqueue.
- Sizes: byte, half, word.
- Half accesses must be 2-byte aligned; word accesses must be word-aligned.
- Misaligned accesses are outside the contract.

**Enqueue**
- A store is written at tail when `alloc_valid && alloc_ready`.
- tail advances modulo N.

**Commit**
- The oldest valid, uncommitted entry whose rob_id equals commit_rob_id is marked committed.
- Commits arrive in program order, so committed entries always form a contiguous run starting at head.
- A commit that matches no entry is ignored.

**Drain**
- cache_req_valid is high when head is valid and committed.
- On `cache_req_valid && cache_req_ready`:
  - the head entry is invalidated;
  - head advances modulo N.
- cache_req_* outputs are driven combinationally from the head entry's registers and stay stable while stalled.

**Flush**
- tail is set to `head + ncommitted` (modulo N), where ncommitted counts committed entries after this cycle's commit and pop.
- Committed entries survive a flush and continue to drain.

**Forwarding (combinational)**
- Only entries valid at the start of the cycle are searched.
- For each byte lane the load needs, the youngest valid entry with the same word address and that lane enabled supplies the byte.
- All needed lanes covered: fwd_hit=1, fwd_conflict=0. fwd_data is the gathered bytes shifted right by `ld_addr[1:0]*8`, with unused upper bytes set to 0.
- Some but not all lanes covered: fwd_conflict=1, fwd_hit=0.
- No lanes covered: both flags 0.
- fwd_data is 0 whenever fwd_hit=0.

**Simultaneous events (order of application within one edge)**
1. commit
2. pop
3. flush
4. enqueue (blocked by flush)

- Enqueue and pop in the same cycle keep count unchanged.
- alloc_ready uses the registered full flag, so a full queue rejects an enqueue even in a cycle where it pops.
- Pointer wrap-around is handled with an explicit count; `full = (count == N)`.

## Timing
- Reset is taken at the first posedge with rst=1 and overrides all other inputs. A reset mid-drain drops the pending cache request.
- Reset values:
  - head=tail=count=0, all valid and committed bits cleared;
  - empty=1, full=0, alloc_ready=1 (when flush=0);
  - cache_req_valid=0, cache_req_addr/data/be=0;
  - fwd_hit=fwd_conflict=0, fwd_data=0.
- Enqueue to forwarding visibility: 1 cycle.
- Commit to cache_req_valid: 1 cycle, provided the entry is at head.
- Drain throughput: 1 store per cycle with cache_req_ready held high.
- Forwarding has zero-cycle latency from ld_addr/ld_size.

## Structure
- Package sq_pkg:
  - size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - function byte_mask(addr_lo, size);
  - function lane_shift(data, addr_lo).
  - Included alongside the shared defines.
- Sub-module sq_fwd_lane:
  - one instance per byte lane;
  - given per-entry match vectors plus head/tail, returns covered and byte using a youngest-first priority over the circular order.

## Test plan
- Reset, then enqueue word store 0x1000←0xDEADBEEF (rob 3) and a word load at 0x1000 → fwd_hit=1, fwd_data=0xDEADBEEF. Byte load at 0x1002 → fwd_data=0x000000AD.
- Byte store 0x2001←0x55 followed by a word load at 0x2000 → fwd_conflict=1, fwd_hit=0. Add a word store 0x2000←0x11223344 (younger) → hit, fwd_data=0x11223344. Half load at 0x2000 after a younger byte store 0x2001←0x55 → fwd_data=0x00005544.
- Fill N=8 entries → full=1, alloc_ready=0. Commit rob ids in order with cache_req_ready=1 → one pop per cycle, count decrements to 0, pointers wrap correctly across a second fill.
- Queue 4 stores and commit 2, then assert flush with alloc_valid=1 → count=2, alloc rejected, and both committed stores still drain with correct be/data.
- Hold cache_req_ready=0 for 3 cycles → cache_req_* stable. Assert rst mid-stall → cache_req_valid=0 and empty=1 on the next cycle.
